// File: rtl/pc_sequencer_if.sv
// Bus between the instruction sequencer (master) and its decoder/fetch environment (slave).
// Optional interrupt signals exist only when PC_SEQUENCER_IRQ_EN is defined.
interface pc_sequencer_if #(
  parameter int unsigned PC_WIDTH = 16
);
  localparam int unsigned SEL_W = 2;
  localparam int unsigned CNT_W = 16;

  logic                stall;
  logic                mem_ready;
  logic                is_jump;
  logic                is_branch;
  logic                branch_taken;
  logic [PC_WIDTH-1:0] jump_target;
  logic [PC_WIDTH-1:0] branch_target;
  logic [PC_WIDTH-1:0] pc;
  logic [SEL_W-1:0]    pc_sel;
  logic                pc_write;
  logic                fetch_req;
  logic                ir_write;
  logic [1:0]          state;
  logic [CNT_W-1:0]    retired;
`ifdef PC_SEQUENCER_IRQ_EN
  logic                irq;
  logic                irq_ack;
  logic [PC_WIDTH-1:0] epc;
`endif

  modport master (
    input  stall, mem_ready, is_jump, is_branch, branch_taken, jump_target, branch_target,
    output pc, pc_sel, pc_write, fetch_req, ir_write, state, retired
`ifdef PC_SEQUENCER_IRQ_EN
    , input irq, output irq_ack, output epc
`endif
  );

  modport slave (
    output stall, mem_ready, is_jump, is_branch, branch_taken, jump_target, branch_target,
    input  pc, pc_sel, pc_write, fetch_req, ir_write, state, retired
`ifdef PC_SEQUENCER_IRQ_EN
    , output irq, input irq_ack, input epc
`endif
  );
endinterface

// File: rtl/pc_sequencer.sv
// Four-state FETCH/DECODE/EXECUTE/WRITEBACK sequencer owning the PC and retired count.
// Define PC_SEQUENCER_IRQ_EN to add edge-triggered interrupt entry with irq_ack/epc.
module pc_sequencer #(
  parameter int unsigned         PC_WIDTH     = 16,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = 16'h0000,
  parameter logic [PC_WIDTH-1:0] IRQ_VECTOR   = 16'h0010
) (
  input logic                 clk,
  input logic                 reset,
  pc_sequencer_if.master      bus
);
  localparam int unsigned SEL_W = 2;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    S_FETCH     = 2'b00,
    S_DECODE    = 2'b01,
    S_EXECUTE   = 2'b10,
    S_WRITEBACK = 2'b11
  } state_t;

  localparam logic [SEL_W-1:0] SEL_SEQ    = 2'b00;
  localparam logic [SEL_W-1:0] SEL_BRANCH = 2'b01;
  localparam logic [SEL_W-1:0] SEL_JUMP   = 2'b10;

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [SEL_W-1:0]    pc_sel_q, pc_sel_d;
  logic [PC_WIDTH-1:0] jt_q, jt_d;
  logic [PC_WIDTH-1:0] bt_q, bt_d;
  logic [CNT_W-1:0]    retired_q, retired_d;
  logic [PC_WIDTH-1:0] next_pc;
  logic                fetch_req_c;
  logic                ir_write_c;
  logic                pc_write_c;
  logic [SEL_W-1:0]    pc_sel_c;

`ifdef PC_SEQUENCER_IRQ_EN
  logic                irq_q;
  logic                irq_pending_q, irq_pending_d;
  logic [PC_WIDTH-1:0] epc_q, epc_d;
  logic                irq_ack_c;
  logic                irq_edge;

  assign irq_edge = bus.irq & ~irq_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_VECTOR;
      pc_sel_q  <= SEL_SEQ;
      jt_q      <= '0;
      bt_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pc_sel_q  <= pc_sel_d;
      jt_q      <= jt_d;
      bt_q      <= bt_d;
      retired_q <= retired_d;
    end
  end

`ifdef PC_SEQUENCER_IRQ_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_q         <= 1'b0;
      irq_pending_q <= 1'b0;
      epc_q         <= '0;
    end else begin
      irq_q         <= bus.irq;
      irq_pending_q <= irq_pending_d;
      epc_q         <= epc_d;
    end
  end
`endif

  // Next-state, datapath updates and combinational strobes.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pc_sel_d    = pc_sel_q;
    jt_d        = jt_q;
    bt_d        = bt_q;
    retired_d   = retired_q;
    next_pc     = pc_q + PC_WIDTH'(1);
    fetch_req_c = 1'b0;
    ir_write_c  = 1'b0;
    pc_write_c  = 1'b0;
    pc_sel_c    = pc_sel_q;
`ifdef PC_SEQUENCER_IRQ_EN
    irq_pending_d = irq_pending_q | irq_edge;
    epc_d         = epc_q;
    irq_ack_c     = 1'b0;
`endif

    if (!reset) begin
      unique case (state_q)
        S_FETCH: begin
          fetch_req_c = 1'b1;
          if (!bus.stall && bus.mem_ready) begin
            ir_write_c = 1'b1;
            state_d    = S_DECODE;
          end
        end
        S_DECODE: begin
          if (!bus.stall) begin
            if (bus.is_jump)                          pc_sel_d = SEL_JUMP;
            else if (bus.is_branch && bus.branch_taken) pc_sel_d = SEL_BRANCH;
            else                                      pc_sel_d = SEL_SEQ;
            jt_d    = bus.jump_target;
            bt_d    = bus.branch_target;
            state_d = S_EXECUTE;
          end
        end
        S_EXECUTE: begin
          if (!bus.stall) state_d = S_WRITEBACK;
        end
        S_WRITEBACK: begin
          if (!bus.stall) begin
            unique case (pc_sel_q)
              SEL_BRANCH: next_pc = bt_q;
              SEL_JUMP:   next_pc = jt_q;
              default:    next_pc = pc_q + PC_WIDTH'(1);
            endcase
            pc_write_c = 1'b1;
            pc_d       = next_pc;
            retired_d  = retired_q + CNT_W'(1);
            pc_sel_d   = SEL_SEQ;
            state_d    = S_FETCH;
`ifdef PC_SEQUENCER_IRQ_EN
            // Interrupt entry redirects the PC but the current instruction still retires.
            if (irq_pending_q) begin
              epc_d         = next_pc;
              pc_d          = IRQ_VECTOR;
              irq_ack_c     = 1'b1;
              pc_sel_c      = 2'b11;
              irq_pending_d = irq_edge;
            end
`endif
          end
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  assign bus.pc        = pc_q;
  assign bus.pc_sel    = pc_sel_c;
  assign bus.pc_write  = pc_write_c;
  assign bus.fetch_req = fetch_req_c;
  assign bus.ir_write  = ir_write_c;
  assign bus.state     = state_q;
  assign bus.retired   = retired_q;
`ifdef PC_SEQUENCER_IRQ_EN
  assign bus.irq_ack   = irq_ack_c;
  assign bus.epc       = epc_q;
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized self-checking bench for pc_sequencer with an instruction-level PC/retire model.
// Interrupt scenario runs only when PC_SEQUENCER_IRQ_EN is defined.
module tb_pc_sequencer;
  localparam int unsigned PW      = 16;
  localparam logic [15:0] IRQ_VEC = 16'h0010;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pc_sequencer_if #(.PC_WIDTH(PW)) bus();

  pc_sequencer #(
    .PC_WIDTH(PW), .RESET_VECTOR(16'h0000), .IRQ_VECTOR(IRQ_VEC)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [15:0] m_pc;
  logic [15:0] m_ret;
  bit          irq_in_exec = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Decoder inputs are don't-care outside the sampling cycle; scramble them.
  task automatic rand_decode();
    bus.is_jump       = 1'($urandom);
    bus.is_branch     = 1'($urandom);
    bus.branch_taken  = 1'($urandom);
    bus.jump_target   = 16'($urandom);
    bus.branch_target = 16'($urandom);
  endtask

  // One instruction: fetch waits, then `stalls` stall cycles in every phase.
  task automatic run_instr(input bit j, input bit b, input bit tk, input logic [15:0] jt,
                           input logic [15:0] bt, input int fetch_wait, input int stalls,
                           input string tag);
    logic [1:0]  sel;
    logic [15:0] nxt;
    logic [4:0]  obs;
    sel = j ? 2'b10 : ((b && tk) ? 2'b01 : 2'b00);
    nxt = j ? jt : ((b && tk) ? bt : m_pc + 16'd1);

    for (int i = 0; i < fetch_wait + stalls; i++) begin
      bus.stall     = (i >= fetch_wait);
      bus.mem_ready = bus.stall;
      rand_decode();
      #1;
      obs = {bus.state, bus.fetch_req, bus.ir_write, bus.pc_write};
      if (obs !== 5'b00_1_0_0) begin
        failures++; $display("FAIL %s fetch_hold: got %b exp %b", tag, obs, 5'b00100);
      end
      checks++;
      tick();
    end
    bus.stall = 1'b0; bus.mem_ready = 1'b1;
    #1;
    obs = {bus.state, bus.fetch_req, bus.ir_write, bus.pc_write};
    if (obs !== 5'b00_1_1_0) begin
      failures++; $display("FAIL %s fetch_accept: got %b exp %b", tag, obs, 5'b00110);
    end
    checks++;
    tick();

    for (int i = 0; i <= stalls; i++) begin
      bus.mem_ready = 1'($urandom);
      if (i < stalls) begin
        bus.stall = 1'b1; rand_decode();
      end else begin
        bus.stall = 1'b0;
        bus.is_jump = j; bus.is_branch = b; bus.branch_taken = tk;
        bus.jump_target = jt; bus.branch_target = bt;
      end
      #1;
      obs = {bus.state, bus.fetch_req, bus.ir_write, bus.pc_write};
      if (obs !== 5'b01_0_0_0 || bus.pc_sel !== 2'b00) begin
        failures++; $display("FAIL %s decode: got %b sel %b exp 01000 sel 00", tag, obs, bus.pc_sel);
      end
      checks++;
      tick();
    end
    rand_decode();

    if (irq_in_exec) begin
`ifdef PC_SEQUENCER_IRQ_EN
      bus.irq = 1'b1;
`endif
    end
    for (int i = 0; i <= stalls; i++) begin
      bus.stall     = (i < stalls);
      bus.mem_ready = 1'($urandom);
      #1;
      obs = {bus.state, bus.fetch_req, bus.ir_write, bus.pc_write};
      if (obs !== 5'b10_0_0_0 || bus.pc_sel !== sel || bus.pc !== m_pc || bus.retired !== m_ret) begin
        failures++;
        $display("FAIL %s execute: got %b sel %b pc %h ret %0d exp 10000 sel %b pc %h ret %0d",
                 tag, obs, bus.pc_sel, bus.pc, bus.retired, sel, m_pc, m_ret);
      end
      checks++;
      tick();
    end

    for (int i = 0; i < stalls; i++) begin
      bus.stall = 1'b1;
      #1;
      obs = {bus.state, bus.fetch_req, bus.ir_write, bus.pc_write};
      if (obs !== 5'b11_0_0_0 || bus.pc_sel !== sel || bus.retired !== m_ret) begin
        failures++; $display("FAIL %s wb_stall: got %b sel %b ret %0d exp 11000 sel %b", tag, obs, bus.pc_sel, bus.retired, sel);
      end
      checks++;
      tick();
    end
    bus.stall = 1'b0;
    #1;
    obs = {bus.state, bus.fetch_req, bus.ir_write, bus.pc_write};
    if (obs !== 5'b11_0_0_1 || bus.pc_sel !== (irq_in_exec ? 2'b11 : sel)) begin
      failures++; $display("FAIL %s writeback: got %b sel %b exp 11001 sel %b", tag, obs, bus.pc_sel, irq_in_exec ? 2'b11 : sel);
    end
    checks++;
`ifdef PC_SEQUENCER_IRQ_EN
    if (bus.irq_ack !== irq_in_exec) begin
      failures++; $display("FAIL %s irq_ack: got %b exp %b", tag, bus.irq_ack, irq_in_exec);
    end
    checks++;
`endif
    tick();

    m_ret = m_ret + 16'd1;
    if (irq_in_exec) begin
`ifdef PC_SEQUENCER_IRQ_EN
      if (bus.epc !== nxt) begin
        failures++; $display("FAIL %s epc: got %h exp %h", tag, bus.epc, nxt);
      end
      checks++;
`endif
      m_pc = IRQ_VEC;
    end else begin
      m_pc = nxt;
    end
    if (bus.pc !== m_pc || bus.retired !== m_ret || bus.state !== 2'b00 || bus.pc_sel !== 2'b00) begin
      failures++;
      $display("FAIL %s retire: got pc %h ret %0d st %b sel %b exp pc %h ret %0d st 00 sel 00",
               tag, bus.pc, bus.retired, bus.state, bus.pc_sel, m_pc, m_ret);
    end
    checks++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_pc  = 16'h0000;
    m_ret = 16'd0;
    #1;
  endtask

  task automatic test_reset();
    bus.stall = 1'b0; bus.mem_ready = 1'b1;
    reset = 1'b1;
    tick();
    if (bus.state !== 2'b00 || bus.pc !== 16'h0000 || bus.pc_sel !== 2'b00 || bus.retired !== 16'd0) begin
      failures++; $display("FAIL reset_regs: got st %b pc %h sel %b ret %0d exp 00 0000 00 0", bus.state, bus.pc, bus.pc_sel, bus.retired);
    end
    checks++;
    if ({bus.fetch_req, bus.ir_write, bus.pc_write} !== 3'b000) begin
      failures++; $display("FAIL reset_strobes: got %b exp 000", {bus.fetch_req, bus.ir_write, bus.pc_write});
    end
    checks++;
    reset = 1'b0;
    m_pc = 16'h0000; m_ret = 16'd0;
    #1;
    if (bus.fetch_req !== 1'b1) begin
      failures++; $display("FAIL reset_release_fetch: got %b exp 1", bus.fetch_req);
    end
    checks++;
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 3; i++) run_instr(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 0, 0, "seq");
    if (bus.pc !== 16'h0003 || bus.retired !== 16'd3) begin
      failures++; $display("FAIL seq_total: got pc %h ret %0d exp 0003 3", bus.pc, bus.retired);
    end
    checks++;
  endtask

  task automatic test_jump_priority();
    run_instr(1'b1, 1'b1, 1'b1, 16'h0ABC, 16'h5555, 0, 0, "jump_prio");
  endtask

  task automatic test_branch();
    run_instr(1'b0, 1'b1, 1'b0, 16'h7777, 16'h1234, 0, 0, "branch_nt");
    run_instr(1'b0, 1'b1, 1'b1, 16'h7777, 16'h1234, 0, 0, "branch_t");
  endtask

  task automatic test_stall();
    run_instr(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 5, 3, "stall");
  endtask

  task automatic test_wrap();
    run_instr(1'b1, 1'b0, 1'b0, 16'hFFFF, 16'h0, 0, 0, "to_ffff");
    run_instr(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 0, 0, "wrap");
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      run_instr(1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), "rand");
    end
  endtask

  task automatic test_async_reset();
    run_instr(1'b1, 1'b0, 1'b0, 16'h4321, 16'h0, 0, 0, "pre_rst");
    bus.stall = 1'b0; bus.mem_ready = 1'b1;
    tick();
    tick();
    if (bus.state !== 2'b10) begin
      failures++; $display("FAIL async_reach_exec: got %b exp 10", bus.state);
    end
    checks++;
    reset = 1'b1;
    #1;
    if (bus.state !== 2'b00 || bus.pc !== 16'h0000 || bus.retired !== 16'd0 ||
        {bus.fetch_req, bus.ir_write, bus.pc_write} !== 3'b000) begin
      failures++; $display("FAIL async_reset: got st %b pc %h ret %0d exp 00 0000 0", bus.state, bus.pc, bus.retired);
    end
    checks++;
    tick();
    reset = 1'b0;
    m_pc = 16'h0000; m_ret = 16'd0;
    #1;
    run_instr(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 0, 0, "post_rst");
  endtask

`ifdef PC_SEQUENCER_IRQ_EN
  task automatic test_irq();
    bus.irq = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) run_instr(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 0, 0, "irq_pre");
    irq_in_exec = 1'b1;
    run_instr(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 0, 0, "irq_entry");
    irq_in_exec = 1'b0;
    if (bus.pc !== 16'h0010 || bus.epc !== 16'h0006) begin
      failures++; $display("FAIL irq_vector: got pc %h epc %h exp 0010 0006", bus.pc, bus.epc);
    end
    checks++;
    run_instr(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 0, 0, "irq_level_held");
    bus.irq = 1'b0;
  endtask
`endif

  initial begin
    reset = 1'b1;
    bus.stall = 1'b0; bus.mem_ready = 1'b0;
    rand_decode();
`ifdef PC_SEQUENCER_IRQ_EN
    bus.irq = 1'b0;
`endif
    test_reset();
    test_sequential();
    test_jump_priority();
    test_branch();
    test_stall();
    test_wrap();
    test_random();
    test_async_reset();
`ifdef PC_SEQUENCER_IRQ_EN
    test_irq();
`else
    do_reset();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Multi-cycle instruction sequencer that owns the 16-bit program counter.
- Drives the 2-bit select of the 4:1 16-bit PC mux and the PC/IR load strobes.
- Sits between the decoder and the fetch path.
- Four-state FSM: FETCH, DECODE, EXECUTE, WRITEBACK. Counts retired instructions.

Parameters:
- PC_WIDTH, 16, width of the PC and target buses.
- RESET_VECTOR, 16'h0000, PC value after reset.
- IRQ_VECTOR, 16'h0010, PC loaded on interrupt entry (only with IRQ_EN).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- stall  in  1  freezes the FSM in its current state.
- mem_ready  in  1  instruction fetch handshake complete.
- is_jump  in  1  decoded jump, sampled in DECODE.
- is_branch  in  1  decoded branch, sampled in DECODE.
- branch_taken  in  1  branch condition, sampled in DECODE.
- jump_target  in  PC_WIDTH  sampled in DECODE.
- branch_target  in  PC_WIDTH  sampled in DECODE.
- pc  out  PC_WIDTH  current PC (registered).
- pc_sel  out  2  PC mux select: 00 PC+1, 01 branch, 10 jump, 11 IRQ vector.
- pc_write  out  1  PC load strobe.
- fetch_req  out  1  instruction fetch request.
- ir_write  out  1  instruction register load strobe.
- state  out  2  FETCH=00, DECODE=01, EXECUTE=10, WRITEBACK=11.
- retired  out  16  retired-instruction count, wraps at 16'hFFFF->0.

Behaviour:
- Reset (async, any state, mid-operation included):
  - state=FETCH, pc=RESET_VECTOR, pc_sel=00, retired=0.
  - Latched targets cleared to 0.
  - pc_write=0, ir_write=0, fetch_req=0 while reset is high.
- FETCH:
  - fetch_req=1.
  - mem_ready=1 and stall=0: ir_write=1 in that same cycle; next state DECODE.
  - Otherwise hold, fetch_req stays 1.
- DECODE (stall=0):
  - Register pc_sel: 10 if is_jump (jump has priority over branch); else 01 if is_branch and branch_taken; else 00.
  - Latch jump_target and branch_target.
  - Next state EXECUTE.
- EXECUTE (stall=0): next state WRITEBACK. No strobes.
- WRITEBACK (stall=0):
  - pc_write=1 for exactly one cycle.
  - pc loads per pc_sel: 00 pc+1 (mod 2^16, 16'hFFFF->16'h0000), 01 latched branch target, 10 latched jump target.
  - retired increments by 1.
  - Next state FETCH; pc_sel returns to 00.
- stall=1 in any state:
  - State, pc, pc_sel, latched targets and retired hold.
  - pc_write=0, ir_write=0; mem_ready is ignored.
  - fetch_req keeps its state-based value.
- Strobe outputs (fetch_req, ir_write, pc_write) are combinational from state, stall and mem_ready.
- pc, pc_sel and retired are registered.
- Minimum instruction latency is 4 cycles with mem_ready=1 in the first FETCH cycle.
- Decoder inputs are don't-care outside DECODE.

Optional Feature:
- Macro: PC_SEQUENCER_IRQ_EN.
- When defined, adds ports irq (in 1), irq_ack (out 1) and epc (out PC_WIDTH, reset 0).
- Pending flag:
  - irq is registered.
  - A rising edge sets irq_pending.
  - Taking the interrupt clears irq_pending.
  - Level-held irq does not re-trigger.
- Interrupt entry, in WRITEBACK with stall=0 and irq_pending=1:
  - epc <= the PC value that would have loaded.
  - pc <= IRQ_VECTOR; pc_sel is driven 11 during that cycle.
  - irq_ack=1 for one cycle.
  - The instruction still retires.
- An edge arriving in the same cycle as entry stays pending.
- When not defined: the ports are absent, pc_sel never equals 11, and all other behaviour is identical.

Test Plan:
- Reset with mem_ready=1, no branches, 3 instructions -> pc 0000->0001->0002->0003; pc_write pulses every 4th cycle; retired=3.
- DECODE with is_jump=1, jump_target=16'h0ABC, is_branch=1, branch_taken=1 -> pc_sel=10; pc=0ABC after WRITEBACK.
- is_branch=1, branch_taken=0, branch_target=16'h1234 -> pc_sel=00; pc=old+1. With branch_taken=1 -> pc=1234.
- mem_ready held 0 for 5 cycles, then stall=1 for 3 cycles in EXECUTE -> FSM holds; no pc_write or ir_write; retired unchanged; completes afterward.
- pc=16'hFFFF sequential instruction -> pc=16'h0000. Reset asserted mid-EXECUTE -> state=00 and pc=RESET_VECTOR immediately, without waiting for a clock edge.
- With PC_SEQUENCER_IRQ_EN: irq rises during EXECUTE at pc=0005 -> WRITEBACK gives pc=0010, epc=0006, irq_ack pulse; irq held high thereafter does not re-enter.
